// File: rtl/uop_fetch_stage.sv
// uop_fetch_stage: first stage of the microcode front end. It fetches one
// two-instruction bundle per cycle from the uop buffer, tags each instruction
// with its speculation depth and hands the pair to decode.
//
// Bundle layout on uop:           {instr_1[31:0], instr_2[31:0]}
// Fetched instruction layout:     {instruction[31:0], branch_tag[MAX_PREDICT_DEPTH_BITS-1:0]}
module uop_fetch_stage #(
  parameter int unsigned UOP_BUF_SIZE           = 256,
  parameter int unsigned MAX_PREDICT_DEPTH_BITS = 2,
  parameter logic [5:0]  BRANCH_OPCODE          = 6'b000100
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 enabled,
  input  logic                                 next_enabled,
  input  logic                                 next_stalled,
  input  logic                                 prev_valid,
  input  logic [63:0]                          uop,
  output logic [$clog2(UOP_BUF_SIZE)-1:0]      uop_addr,
  output logic                                 stalled,
  output logic                                 valid,
  output logic [32+MAX_PREDICT_DEPTH_BITS-1:0] instruction_1,
  output logic [32+MAX_PREDICT_DEPTH_BITS-1:0] instruction_2
);

  localparam int unsigned AddrW  = $clog2(UOP_BUF_SIZE);
  localparam int unsigned DepthW = MAX_PREDICT_DEPTH_BITS;
  localparam int unsigned FetchW = 32 + DepthW;

  logic [AddrW-1:0]  addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic [FetchW-1:0] instr1_q, instr1_d;
  logic [FetchW-1:0] instr2_q, instr2_d;

  logic [31:0]       uop_instr_1, uop_instr_2;
  logic              b1, b2;
  logic [DepthW-1:0] depth_after_1;

  assign uop_instr_1 = uop[63:32];
  assign uop_instr_2 = uop[31:0];

  // Branch detection on the bundle currently presented by the buffer.
  assign b1 = (uop_instr_1[31:26] == BRANCH_OPCODE);
  assign b2 = (uop_instr_2[31:26] == BRANCH_OPCODE);

  // The younger instruction sees the depth bumped by an older branch.
  assign depth_after_1 = depth_q + DepthW'(b1);

  // Next-state selection in priority order: clear, load, drop, consume, hold.
  always_comb begin
    addr_d   = addr_q;
    valid_d  = valid_q;
    depth_d  = depth_q;
    instr1_d = instr1_q;
    instr2_d = instr2_q;
    if (clear) begin
      valid_d = 1'b0;
      depth_d = '0;
    end else if (enabled && prev_valid) begin
      instr1_d = {uop_instr_1, depth_q};
      instr2_d = {uop_instr_2, depth_after_1};
      valid_d  = 1'b1;
      addr_d   = addr_q + AddrW'(1);
      depth_d  = depth_after_1 + DepthW'(b2);
    end else if (enabled) begin
      valid_d = 1'b0;
    end else if (next_enabled) begin
      // Decode took the bundle and nothing replaces it.
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      valid_q  <= 1'b0;
      depth_q  <= '0;
      instr1_q <= '0;
      instr2_q <= '0;
    end else begin
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      depth_q  <= depth_d;
      instr1_q <= instr1_d;
      instr2_q <= instr2_d;
    end
  end

  // A held bundle blocks new input while decode is stalled.
  assign stalled       = valid_q && next_stalled;
  assign uop_addr      = addr_q;
  assign valid         = valid_q;
  assign instruction_1 = instr1_q;
  assign instruction_2 = instr2_q;

endmodule

// File: tb/tb_uop_fetch_stage.sv
// Scoreboard bench for uop_fetch_stage: a small buffer/stage model pushes the
// expected bundle when a load is driven and pops it when the DUT shows it.
module tb_uop_fetch_stage;

  localparam int unsigned Size = 256;
  localparam int unsigned AW   = 8;
  localparam int unsigned FW   = 34;
  localparam logic [5:0]  Br   = 6'b000100;

  logic          clk = 1'b0;
  logic          reset = 1'b1, clear = 1'b0, enabled = 1'b0, next_enabled = 1'b0;
  logic          next_stalled = 1'b0, prev_valid = 1'b1;
  logic [63:0]   uop;
  logic [AW-1:0] uop_addr;
  logic          stalled, valid;
  logic [FW-1:0] instruction_1, instruction_2;

  logic [63:0]   mem [Size];
  assign uop = mem[uop_addr];

  uop_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .enabled       (enabled),
    .next_enabled  (next_enabled),
    .next_stalled  (next_stalled),
    .prev_valid    (prev_valid),
    .uop           (uop),
    .uop_addr      (uop_addr),
    .stalled       (stalled),
    .valid         (valid),
    .instruction_1 (instruction_1),
    .instruction_2 (instruction_2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  logic [AW-1:0]     m_addr = '0;
  logic [1:0]        m_depth = '0;
  logic              m_valid = 1'b0;
  logic [2*FW-1:0]   cur = '0;
  logic [2*FW-1:0]   exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic clr, input logic ns, input logic pv,
                      input bit force_take = 1'b0);
    logic en, ne, load, b1, b2;
    logic [63:0] word;
    @(negedge clk);
    reset        = rst;
    clear        = clr;
    next_stalled = ns;
    prev_valid   = pv;
    if (force_take) begin
      en = 1'b0;
      ne = 1'b1;
    end else begin
      en = !(m_valid && ns);
      ne = m_valid && !ns;
    end
    enabled      = en;
    next_enabled = ne;
    #1;
    chk("stalled", 64'(stalled), 64'(m_valid && ns));
    load = 1'b0;
    if (rst) begin
      m_addr = '0; m_valid = 1'b0; m_depth = '0; cur = '0;
      exp_q.delete();
    end else if (clr) begin
      m_valid = 1'b0; m_depth = '0;
    end else if (en && pv) begin
      word = mem[m_addr];
      b1 = (word[63:58] == Br);
      b2 = (word[31:26] == Br);
      exp_q.push_back({word[63:32], m_depth, word[31:0], 2'(m_depth + 2'(b1))});
      m_depth = m_depth + 2'(b1) + 2'(b2);
      m_addr  = m_addr + 8'd1;
      m_valid = 1'b1;
      load = 1'b1;
    end else if (en || ne) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (load) begin
      if (exp_q.size() == 0) chk("queue_empty", 64'd0, 64'd1);
      else cur = exp_q.pop_front();
    end
    chk("valid", 64'(valid), 64'(m_valid));
    chk("uop_addr", 64'(uop_addr), 64'(m_addr));
    chk("instruction_1", 64'(instruction_1), 64'(cur[2*FW-1:FW]));
    chk("instruction_2", 64'(instruction_2), 64'(cur[FW-1:0]));
  endtask

  logic [AW-1:0] saved_addr;
  logic [FW-1:0] saved_i1;

  initial begin
    for (int a = 0; a < int'(Size); a++) begin
      mem[a] = {32'h1000 + 32'(2 * a), 32'h1001 + 32'(2 * a)};
    end

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_addr", 64'(uop_addr), 64'd0);

    // Free run: first bundles arrive one cycle after reset drops.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b0_i1", 64'(instruction_1[33:2]), 64'h1000);
    chk("b0_i2", 64'(instruction_2[33:2]), 64'h1001);
    chk("b0_addr", 64'(uop_addr), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b1_i1", 64'(instruction_1[33:2]), 64'h1002);
    chk("b1_i2", 64'(instruction_2[33:2]), 64'h1003);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Stall for three cycles: everything frozen, then resume with no gap.
    saved_addr = uop_addr;
    saved_i1   = instruction_1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("stall_addr", 64'(uop_addr), 64'(saved_addr));
      chk("stall_i1", 64'(instruction_1), 64'(saved_i1));
      chk("stall_valid", 64'(valid), 64'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume_i1", 64'(instruction_1[33:2]), 64'h1000 + 64'(2 * int'(saved_addr)));

    // Run long enough for the address to wrap.
    for (int i = 0; i < int'(Size) + 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Branch tags: {br,alu}, {br,br}, {alu,alu}.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    mem[0] = {Br, 26'h11, 32'h0000_0022};
    mem[1] = {Br, 26'h33, Br, 26'h44};
    mem[2] = {32'h0000_0055, 32'h0000_0066};
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tag0_1", 64'(instruction_1[1:0]), 64'd0);
    chk("tag0_2", 64'(instruction_2[1:0]), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tag1_1", 64'(instruction_1[1:0]), 64'd1);
    chk("tag1_2", 64'(instruction_2[1:0]), 64'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tag2_1", 64'(instruction_1[1:0]), 64'd3);
    chk("tag2_2", 64'(instruction_2[1:0]), 64'd3);

    // Clear during a stall drops the bundle and resets the depth.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    saved_addr = uop_addr;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_valid", 64'(valid), 64'd0);
    chk("clr_addr", 64'(uop_addr), 64'(saved_addr));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_tag_1", 64'(instruction_1[1:0]), 64'd0);
    chk("clr_tag_2", 64'(instruction_2[1:0]), 64'd0);

    // No valid input: bundle dropped, address holds.
    saved_addr = uop_addr;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pv0_valid", 64'(valid), 64'd0);
    chk("pv0_addr", 64'(uop_addr), 64'(saved_addr));

    // Decode takes the bundle while this stage is not loading.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    saved_addr = uop_addr;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("take_valid", 64'(valid), 64'd0);
    chk("take_addr", 64'(uop_addr), 64'(saved_addr));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
